encode_blocker: RTL and testbench



---
 rtl/encode_blocker_pkg.sv | 26 ++
 rtl/encode_blocker_if.sv | 27 ++
 rtl/encode_blocker_rd_ctr.sv | 70 +++++++
 rtl/encode_blocker.sv | 119 +++++++++++
 tb/tb_encode_blocker.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/encode_blocker_pkg.sv
// Shared constants and small helpers for the encode_blocker raster-to-block converter.
// Optional level shift of output pixels is enabled with ENCODE_BLOCKER_LEVEL_SHIFT_EN.
package encode_blocker_pkg;

    localparam int PIXEL_BIT  = 8;
    localparam int BLOCK_SIZE = 8;
    localparam int BLOCK_BIT  = $clog2(BLOCK_SIZE);
    localparam int IMG_WIDTH  = 128;
    localparam int BLOCK_AREA = BLOCK_SIZE * BLOCK_SIZE;
    localparam int BUF_LEN    = BLOCK_SIZE * IMG_WIDTH;
    localparam int NBLK       = IMG_WIDTH / BLOCK_SIZE;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Pointer width must be able to hold BUF_LEN itself, not just BUF_LEN-1.
    function automatic int ptr_width(input int buf_len);
        return $clog2(buf_len + 1);
    endfunction

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/encode_blocker_if.sv
// Stream bundle between the raster source, the blocker and the forward DCT.
// Both streams: a beat transfers on a clock edge where valid and ready are both high;
// the source holds data stable while valid && !ready, and ready never waits on valid.
interface encode_blocker_if #(
    parameter int PIXEL_BIT = encode_blocker_pkg::PIXEL_BIT,
    parameter int BLOCK_BIT = encode_blocker_pkg::BLOCK_BIT
);
    logic [PIXEL_BIT-1:0] ham_veri_i;
    logic                 ham_gecerli_i;
    logic                 ham_hazir_o;
    logic [PIXEL_BIT-1:0] dct_veri_o;
    logic [BLOCK_BIT-1:0] dct_row_o;
    logic [BLOCK_BIT-1:0] dct_col_o;
    logic                 dct_blok_son_o;
    logic                 dct_gecerli_o;
    logic                 dct_hazir_i;

    modport slave (
        input  ham_veri_i, ham_gecerli_i, dct_hazir_i,
        output ham_hazir_o, dct_veri_o, dct_row_o, dct_col_o, dct_blok_son_o, dct_gecerli_o
    );

    modport master (
        output ham_veri_i, ham_gecerli_i, dct_hazir_i,
        input  ham_hazir_o, dct_veri_o, dct_row_o, dct_col_o, dct_blok_son_o, dct_gecerli_o
    );
endinterface

// File: rtl/encode_blocker_rd_ctr.sv
// Read-side counter chain: column fastest, then row, then block across one strip.
// Produces the block-last flag and a one-cycle strip-done pulse on the final read beat.
module encode_blocker_rd_ctr #(
    parameter int BLOCK_SIZE = encode_blocker_pkg::BLOCK_SIZE,
    parameter int BLOCK_BIT  = encode_blocker_pkg::BLOCK_BIT,
    parameter int NBLK       = encode_blocker_pkg::NBLK,
    parameter int BLK_W      = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 adv_i,
    output logic [BLOCK_BIT-1:0] rd_row_o,
    output logic [BLOCK_BIT-1:0] rd_col_o,
    output logic [BLK_W-1:0]     rd_blk_o,
    output logic                 blok_son_o,
    output logic                 strip_done_o
);
    localparam logic [BLOCK_BIT-1:0] EDGE_LAST = BLOCK_BIT'(BLOCK_SIZE - 1);
    localparam logic [BLK_W-1:0]     BLK_LAST  = BLK_W'(NBLK - 1);

    logic [BLOCK_BIT-1:0] row_q, row_d;
    logic [BLOCK_BIT-1:0] col_q, col_d;
    logic [BLK_W-1:0]     blk_q, blk_d;
    logic                 col_end, row_end, blk_end;

    always_comb begin
        col_end = (col_q == EDGE_LAST);
        row_end = (row_q == EDGE_LAST);
        blk_end = (blk_q == BLK_LAST);
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        blk_d = blk_q;
        if (adv_i) begin
            if (!col_end) begin
                col_d = col_q + BLOCK_BIT'(1);
            end else begin
                col_d = '0;
                if (!row_end) begin
                    row_d = row_q + BLOCK_BIT'(1);
                end else begin
                    row_d = '0;
                    blk_d = blk_end ? '0 : blk_q + BLK_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
            blk_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            blk_q <= blk_d;
        end
    end

    assign rd_row_o     = row_q;
    assign rd_col_o     = col_q;
    assign rd_blk_o     = blk_q;
    assign blok_son_o   = valid_i && col_end && row_end;
    assign strip_done_o = adv_i && col_end && row_end && blk_end;

endmodule

// File: rtl/encode_blocker.sv
// Raster-to-block converter: fills one strip buffer while the other drains as blocks.
// Define ENCODE_BLOCKER_LEVEL_SHIFT_EN to emit pixels offset by -2^(PIXEL_BIT-1).
module encode_blocker #(
    parameter int PIXEL_BIT  = encode_blocker_pkg::PIXEL_BIT,
    parameter int BLOCK_SIZE = encode_blocker_pkg::BLOCK_SIZE,
    parameter int IMG_WIDTH  = encode_blocker_pkg::IMG_WIDTH
) (
    input logic            clk_i,
    input logic            rst_i,
    encode_blocker_if.slave bus
);
    import encode_blocker_pkg::*;

    localparam int BLOCK_BIT = $clog2(BLOCK_SIZE);
    localparam int BUF_LEN   = BLOCK_SIZE * IMG_WIDTH;
    localparam int NBLK      = IMG_WIDTH / BLOCK_SIZE;
    localparam int PTR_W     = ptr_width(BUF_LEN);
    localparam int AW        = $clog2(BUF_LEN);
    localparam int BLK_W     = idx_width(NBLK);
    localparam logic [PTR_W-1:0] WR_LAST = PTR_W'(BUF_LEN - 1);

    logic [PIXEL_BIT-1:0] pix_mem [2][BUF_LEN];

    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       full_q, full_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic                 ham_hazir, wr_fire;
    logic                 rd_valid, rd_adv, strip_done, blok_son;
    logic [BLOCK_BIT-1:0] rd_row, rd_col;
    logic [BLK_W-1:0]     rd_blk;
    logic [AW-1:0]        rd_addr;
    logic [PIXEL_BIT-1:0] rd_pix, pix_out;

    assign ham_hazir = !full_q[wr_sel_q];
    assign wr_fire   = bus.ham_gecerli_i && ham_hazir;
    assign rd_valid  = full_q[rd_sel_q];
    assign rd_adv    = rd_valid && bus.dct_hazir_i;

    encode_blocker_rd_ctr #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .BLOCK_BIT (BLOCK_BIT),
        .NBLK      (NBLK),
        .BLK_W     (BLK_W)
    ) u_rd_ctr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (rd_valid),
        .adv_i       (rd_adv),
        .rd_row_o    (rd_row),
        .rd_col_o    (rd_col),
        .rd_blk_o    (rd_blk),
        .blok_son_o  (blok_son),
        .strip_done_o(strip_done)
    );

    // Completing one buffer and freeing the other can coincide; they never hit the same flag.
    always_comb begin
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_ptr_d = wr_ptr_q;
        full_d   = full_q;
        if (wr_fire) begin
            if (wr_ptr_q == WR_LAST) begin
                full_d[wr_sel_q] = HIGH;
                wr_ptr_d         = '0;
                wr_sel_d         = !wr_sel_q;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end
        if (strip_done) begin
            full_d[rd_sel_q] = LOW;
            rd_sel_d         = !rd_sel_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_ptr_q <= '0;
            full_q   <= '0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_ptr_q <= wr_ptr_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_fire) begin
            pix_mem[wr_sel_q][wr_ptr_q[AW-1:0]] <= bus.ham_veri_i;
        end
    end

    // Highest address is BUF_LEN-1, so AW bits hold every legal sum.
    always_comb begin
        rd_addr = AW'(rd_row) * AW'(IMG_WIDTH) + AW'(rd_blk) * AW'(BLOCK_SIZE) + AW'(rd_col);
        rd_pix  = pix_mem[rd_sel_q][rd_addr];
    end

`ifdef ENCODE_BLOCKER_LEVEL_SHIFT_EN
    localparam logic [PIXEL_BIT-1:0] MSB_MASK = PIXEL_BIT'(1) << (PIXEL_BIT - 1);
    assign pix_out = rd_pix ^ MSB_MASK;
`else
    assign pix_out = rd_pix;
`endif

    assign bus.ham_hazir_o    = ham_hazir;
    assign bus.dct_gecerli_o  = rd_valid;
    assign bus.dct_veri_o     = rd_valid ? pix_out : '0;
    assign bus.dct_row_o      = rd_row;
    assign bus.dct_col_o      = rd_col;
    assign bus.dct_blok_son_o = blok_son;

endmodule

// File: tb/tb_encode_blocker.sv
// Self-checking bench for encode_blocker with a 16-pixel-wide image and 8x8 blocks.
// Expected blocks are rebuilt from each accepted raster strip by a reference model.
module tb_encode_blocker;

    localparam int PIXEL_BIT  = 8;
    localparam int BLOCK_SIZE = 8;
    localparam int BLOCK_BIT  = 3;
    localparam int IMG_WIDTH  = 16;
    localparam int BUF_LEN    = BLOCK_SIZE * IMG_WIDTH;
    localparam int NBLK       = IMG_WIDTH / BLOCK_SIZE;
    localparam int EW         = PIXEL_BIT + 2 * BLOCK_BIT + 1;
    localparam int TMO        = 2000;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    encode_blocker_if #(.PIXEL_BIT(PIXEL_BIT), .BLOCK_BIT(BLOCK_BIT)) bus();

    encode_blocker #(
        .PIXEL_BIT (PIXEL_BIT),
        .BLOCK_SIZE(BLOCK_SIZE),
        .IMG_WIDTH (IMG_WIDTH)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int out_cnt  = 0;
    bit prod_done;

    logic [EW-1:0]        exp_q[$];
    logic [PIXEL_BIT-1:0] strip_q[$];
    logic [EW-1:0]        sb_act, sb_exp;

    function automatic logic [PIXEL_BIT-1:0] ref_pix(input logic [PIXEL_BIT-1:0] p);
`ifdef ENCODE_BLOCKER_LEVEL_SHIFT_EN
        return PIXEL_BIT'(int'(p) - (1 << (PIXEL_BIT - 1)));
`else
        return p;
`endif
    endfunction

    // Reference: a strip is BLOCK_SIZE raster rows; emit each block's pixels row by row.
    task automatic model_strip();
        logic [PIXEL_BIT-1:0] p;
        logic                 last;
        for (int b = 0; b < NBLK; b++) begin
            for (int r = 0; r < BLOCK_SIZE; r++) begin
                for (int c = 0; c < BLOCK_SIZE; c++) begin
                    p    = strip_q[r * IMG_WIDTH + b * BLOCK_SIZE + c];
                    last = (r == BLOCK_SIZE - 1) && (c == BLOCK_SIZE - 1);
                    exp_q.push_back({ref_pix(p), BLOCK_BIT'(r), BLOCK_BIT'(c), last});
                end
            end
        end
        strip_q.delete();
    endtask

    // Scoreboard: capture raster beats into the model, compare every block beat.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (bus.ham_gecerli_i && bus.ham_hazir_o) begin
                strip_q.push_back(bus.ham_veri_i);
                if (strip_q.size() == BUF_LEN) model_strip();
            end
            if (bus.dct_gecerli_o && bus.dct_hazir_i) begin
                sb_act = {bus.dct_veri_o, bus.dct_row_o, bus.dct_col_o, bus.dct_blok_son_o};
                checks++;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_extra_beat: got pix=%h row=%0d col=%0d last=%0b, required no beat",
                             bus.dct_veri_o, bus.dct_row_o, bus.dct_col_o, bus.dct_blok_son_o);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (sb_act !== sb_exp) begin
                        failures++;
                        $display("FAIL sb_beat_%0d: got pix=%h row=%0d col=%0d last=%0b, required pix=%h row=%0d col=%0d last=%0b",
                                 out_cnt, sb_act[EW-1 -: PIXEL_BIT], sb_act[2*BLOCK_BIT -: BLOCK_BIT],
                                 sb_act[BLOCK_BIT -: BLOCK_BIT], sb_act[0],
                                 sb_exp[EW-1 -: PIXEL_BIT], sb_exp[2*BLOCK_BIT -: BLOCK_BIT],
                                 sb_exp[BLOCK_BIT -: BLOCK_BIT], sb_exp[0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_pixel(input logic [PIXEL_BIT-1:0] d, output int stalls);
        bus.ham_veri_i    = d;
        bus.ham_gecerli_i = 1'b1;
        stalls            = 0;
        @(negedge clk_i);
        while (!bus.ham_hazir_o && stalls < TMO) begin
            @(negedge clk_i);
            stalls++;
        end
        if (!bus.ham_hazir_o) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: ham_hazir_o=%b after %0d cycles, required 1", bus.ham_hazir_o, stalls);
        end
        tick();
        bus.ham_gecerli_i = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while (exp_q.size() != 0 && n < TMO) begin
            @(negedge clk_i);
            n++;
        end
        ok = (exp_q.size() == 0);
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (bus.ham_hazir_o !== 1'b1) begin failures++; $display("FAIL rst_hazir: got %b, required 1", bus.ham_hazir_o); end
        checks++; if (bus.dct_gecerli_o !== 1'b0) begin failures++; $display("FAIL rst_gecerli: got %b, required 0", bus.dct_gecerli_o); end
        checks++; if (bus.dct_veri_o !== '0) begin failures++; $display("FAIL rst_veri: got %h, required 0", bus.dct_veri_o); end
        checks++; if (bus.dct_row_o !== '0) begin failures++; $display("FAIL rst_row: got %0d, required 0", bus.dct_row_o); end
        checks++; if (bus.dct_col_o !== '0) begin failures++; $display("FAIL rst_col: got %0d, required 0", bus.dct_col_o); end
        checks++; if (bus.dct_blok_son_o !== 1'b0) begin failures++; $display("FAIL rst_son: got %b, required 0", bus.dct_blok_son_o); end
        tick();
    endtask

    task automatic test_order();
        int s;
        int base;
        bit ok;
        base = out_cnt;
        bus.dct_hazir_i = 1'b1;
        for (int i = 0; i < BUF_LEN - 1; i++) push_pixel(PIXEL_BIT'(i), s);
        bus.ham_veri_i    = PIXEL_BIT'(BUF_LEN - 1);
        bus.ham_gecerli_i = 1'b1;
        @(negedge clk_i);
        checks++; if (bus.dct_gecerli_o !== 1'b0) begin failures++; $display("FAIL order_early_valid: got %b, required 0", bus.dct_gecerli_o); end
        tick();
        bus.ham_gecerli_i = 1'b0;
        @(negedge clk_i);
        checks++; if (bus.dct_gecerli_o !== 1'b1) begin failures++; $display("FAIL order_latency: got %b, required 1", bus.dct_gecerli_o); end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL order_drain: left %0d, required 0", exp_q.size()); end
        @(negedge clk_i);
        checks++; if (bus.dct_gecerli_o !== 1'b0) begin failures++; $display("FAIL order_idle_valid: got %b, required 0", bus.dct_gecerli_o); end
        checks++; if (out_cnt - base != BUF_LEN) begin failures++; $display("FAIL order_count: got %0d, required %0d", out_cnt - base, BUF_LEN); end
        tick();
    endtask

    task automatic test_stream();
        int stalls_total = 0;
        int gaps         = 0;
        int base;
        bit ok;
        base = out_cnt;
        bus.dct_hazir_i = 1'b1;
        fork
            begin
                int s;
                for (int k = 0; k < 4 * BUF_LEN; k++) begin
                    push_pixel(PIXEL_BIT'($urandom), s);
                    stalls_total += s;
                end
            end
            begin
                for (int k = 0; k < 4 * BUF_LEN; k++) begin
                    @(negedge clk_i);
                    if (k >= BUF_LEN && !bus.dct_gecerli_o) gaps++;
                end
            end
        join
        checks++; if (stalls_total != 0) begin failures++; $display("FAIL stream_in_stall: got %0d, required 0", stalls_total); end
        checks++; if (gaps != 0) begin failures++; $display("FAIL stream_out_gap: got %0d, required 0", gaps); end
        wait_drain(ok);
        checks++; if (!ok || out_cnt - base != 4 * BUF_LEN) begin failures++; $display("FAIL stream_count: got %0d, required %0d", out_cnt - base, 4 * BUF_LEN); end
    endtask

    task automatic test_backpressure();
        int s;
        int unstable = 0;
        int base;
        bit ok;
        logic [EW-1:0] snap;
        logic [PIXEL_BIT-1:0] d;
        base = out_cnt;
        bus.dct_hazir_i = 1'b0;
        for (int i = 0; i < 2 * BUF_LEN; i++) push_pixel(PIXEL_BIT'($urandom), s);
        d = PIXEL_BIT'($urandom);
        bus.ham_veri_i    = d;
        bus.ham_gecerli_i = 1'b1;
        @(negedge clk_i);
        checks++; if (bus.ham_hazir_o !== 1'b0) begin failures++; $display("FAIL bp_hazir_full: got %b, required 0", bus.ham_hazir_o); end
        checks++; if (bus.dct_gecerli_o !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b, required 1", bus.dct_gecerli_o); end
        snap = {bus.dct_veri_o, bus.dct_row_o, bus.dct_col_o, bus.dct_blok_son_o};
        repeat (16) begin
            @(negedge clk_i);
            if ({bus.dct_veri_o, bus.dct_row_o, bus.dct_col_o, bus.dct_blok_son_o} !== snap ||
                bus.dct_gecerli_o !== 1'b1 || bus.ham_hazir_o !== 1'b0) unstable++;
        end
        checks++; if (unstable != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles, required 0", unstable); end
        tick();
        bus.dct_hazir_i = 1'b1;
        push_pixel(d, s);
        checks++; if (s != BUF_LEN) begin failures++; $display("FAIL bp_resume: got %0d stall cycles, required %0d", s, BUF_LEN); end
        for (int i = 1; i < BUF_LEN; i++) push_pixel(PIXEL_BIT'($urandom), s);
        wait_drain(ok);
        checks++; if (!ok || out_cnt - base != 3 * BUF_LEN) begin failures++; $display("FAIL bp_count: got %0d, required %0d", out_cnt - base, 3 * BUF_LEN); end
    endtask

    task automatic test_reset_mid();
        int s;
        int base;
        bit ok;
        bus.dct_hazir_i = 1'b0;
        for (int i = 0; i < BUF_LEN + 50; i++) push_pixel(PIXEL_BIT'($urandom), s);
        rst_i             = 1'b1;
        bus.ham_gecerli_i = 1'b0;
        exp_q.delete();
        strip_q.delete();
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (bus.ham_hazir_o !== 1'b1) begin failures++; $display("FAIL rmid_hazir: got %b, required 1", bus.ham_hazir_o); end
        checks++; if (bus.dct_gecerli_o !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b, required 0", bus.dct_gecerli_o); end
        checks++; if (bus.dct_row_o !== '0 || bus.dct_col_o !== '0) begin failures++; $display("FAIL rmid_ctr: got row=%0d col=%0d, required 0/0", bus.dct_row_o, bus.dct_col_o); end
        tick();
        base = out_cnt;
        bus.dct_hazir_i = 1'b1;
        for (int i = 0; i < BUF_LEN - 1; i++) push_pixel(PIXEL_BIT'(i + 7), s);
        @(negedge clk_i);
        checks++; if (bus.dct_gecerli_o !== 1'b0 || out_cnt != base) begin failures++; $display("FAIL rmid_partial: got valid=%b beats=%0d, required 0/0", bus.dct_gecerli_o, out_cnt - base); end
        tick();
        push_pixel(PIXEL_BIT'(BUF_LEN + 6), s);
        wait_drain(ok);
        checks++; if (!ok || out_cnt - base != BUF_LEN) begin failures++; $display("FAIL rmid_count: got %0d, required %0d", out_cnt - base, BUF_LEN); end
    endtask

    task automatic test_random();
        int base;
        int n = 0;
        base      = out_cnt;
        prod_done = 1'b0;
        fork
            begin
                int s;
                for (int i = 0; i < 8 * BUF_LEN; i++) begin
                    while ($urandom_range(0, 1) == 0) tick();
                    push_pixel(PIXEL_BIT'($urandom), s);
                end
                prod_done = 1'b1;
            end
            begin
                while ((!prod_done || exp_q.size() != 0) && n < 30000) begin
                    bus.dct_hazir_i = 1'($urandom_range(0, 1));
                    tick();
                    n++;
                end
                bus.dct_hazir_i = 1'b1;
            end
        join
        checks++; if (n >= 30000) begin failures++; $display("FAIL rand_timeout: got %0d cycles, required < 30000", n); end
        checks++; if (out_cnt - base != 8 * BUF_LEN) begin failures++; $display("FAIL rand_count: got %0d, required %0d", out_cnt - base, 8 * BUF_LEN); end
        checks++; if (strip_q.size() != 0 || exp_q.size() != 0) begin failures++; $display("FAIL rand_leftover: got in=%0d out=%0d, required 0/0", strip_q.size(), exp_q.size()); end
        tick();
    endtask

`ifdef ENCODE_BLOCKER_LEVEL_SHIFT_EN
    task automatic test_level_shift();
        int s;
        bit ok;
        bus.dct_hazir_i = 1'b0;
        push_pixel(8'h00, s);
        push_pixel(8'h80, s);
        push_pixel(8'hFF, s);
        for (int i = 3; i < BUF_LEN; i++) push_pixel(8'h40, s);
        @(negedge clk_i);
        checks++; if (bus.dct_veri_o !== 8'h80) begin failures++; $display("FAIL ls_00: got %h, required 80", bus.dct_veri_o); end
        tick();
        bus.dct_hazir_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++; if (bus.dct_veri_o !== 8'h00) begin failures++; $display("FAIL ls_80: got %h, required 00", bus.dct_veri_o); end
        @(negedge clk_i);
        checks++; if (bus.dct_veri_o !== 8'h7F) begin failures++; $display("FAIL ls_ff: got %h, required 7f", bus.dct_veri_o); end
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ls_drain: left %0d, required 0", exp_q.size()); end
    endtask
`endif

    initial begin
        bus.ham_veri_i    = '0;
        bus.ham_gecerli_i = 1'b0;
        bus.dct_hazir_i   = 1'b0;
        test_reset();
        test_order();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef ENCODE_BLOCKER_LEVEL_SHIFT_EN
        test_level_shift();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
